// File: rtl/ks_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ks_subtractor_pipe
// Brief   : Pipelined Kogge-Stone subtractor, result = a - b - b_in with borrow
//           out and valid/ready handshake; KS_SUB_OVF_EN adds signed overflow.
// Revision: 1.0
// ============================================================================
module ks_subtractor_pipe #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            b_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] result,
    output logic            b_out
`ifdef KS_SUB_OVF_EN
    ,
    output logic            ovf
`endif
);
    localparam int LEVELS = $clog2(SIZE);

    wire  [LEVELS:0][SIZE-1:0]   g_d;
    wire  [LEVELS-1:0][SIZE-1:0] p_d;
    logic [LEVELS:0][SIZE-1:0]   g_q;
    logic [LEVELS-1:0][SIZE-1:0] p_q;
    logic [LEVELS:0][SIZE-1:0]   hs_q, hs_d;
    logic [LEVELS:0]             cin_q, cin_d;
    logic [LEVELS:0]             v_q, v_d;
    logic [SIZE-1:0]             result_q, result_d;
    logic [SIZE-1:0]             carry;
    logic                        b_out_q, b_out_d;
    logic                        out_valid_q, out_valid_d;
    logic                        stall;

    // Subtraction as a + ~b + ~b_in: stage 0 terms use the inverted subtrahend.
    assign g_d[0] = a & ~b;
    assign p_d[0] = a ^ ~b;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int              SPAN     = 1 << (k - 1);
        localparam logic [SIZE-1:0] LOW_MASK = ~({SIZE{1'b1}} << SPAN);
        wire [SIZE-1:0] gin;

        if (k == 1) begin : g_first
            // Carry-in folded into bit 0 so the prefix result is the true carry.
            assign gin = {g_q[0][SIZE-1:1], g_q[0][0] | (p_q[0][0] & cin_q[0])};
        end else begin : g_rest
            assign gin = g_q[k-1];
        end

        assign g_d[k] = gin | (p_q[k-1] & (gin << SPAN));

        if (k < LEVELS) begin : g_prop
            assign p_d[k] = p_q[k-1] & ((p_q[k-1] << SPAN) | LOW_MASK);
        end
    end

    always_comb begin
        stall       = out_valid_q & ~out_ready;
        in_ready    = ~stall;
        hs_d        = {hs_q[LEVELS-1:0], a ^ ~b};
        cin_d       = {cin_q[LEVELS-1:0], ~b_in};
        v_d         = {v_q[LEVELS-1:0], in_valid & ~stall};
        carry       = {g_q[LEVELS][SIZE-2:0], cin_q[LEVELS]};
        result_d    = hs_q[LEVELS] ^ carry;
        b_out_d     = ~g_q[LEVELS][SIZE-1];
        out_valid_d = v_q[LEVELS];
    end

`ifdef KS_SUB_OVF_EN
    logic [LEVELS:0] sa_q, sa_d, sb_q, sb_d;
    logic            ovf_q, ovf_d;

    always_comb begin
        sa_d  = {sa_q[LEVELS-1:0], a[SIZE-1]};
        sb_d  = {sb_q[LEVELS-1:0], b[SIZE-1]};
        ovf_d = (sa_q[LEVELS] ^ sb_q[LEVELS]) & (result_d[SIZE-1] ^ sa_q[LEVELS]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q  <= '0;
            sb_q  <= '0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // A stall freezes every stage, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q         <= '0;
            p_q         <= '0;
            hs_q        <= '0;
            cin_q       <= '0;
            v_q         <= '0;
            result_q    <= '0;
            b_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            g_q         <= g_d;
            p_q         <= p_d;
            hs_q        <= hs_d;
            cin_q       <= cin_d;
            v_q         <= v_d;
            result_q    <= result_d;
            b_out_q     <= b_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign b_out     = b_out_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ks_subtractor_pipe.sv
`default_nettype none
// Bench for ks_subtractor_pipe: directed and random streams scored against
// 65-bit arithmetic, with latency, stall-hold and reset behaviour checked.
module tb_ks_subtractor_pipe;
    localparam int SIZE = 64;
    localparam int LAT  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        b_in = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        in_ready, out_valid, b_out;
    logic [63:0] result;
`ifdef KS_SUB_OVF_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int stall_cnt = 0;
    int n_out = 0;

    typedef struct {
        logic [63:0] res;
        logic        bo;
        logic        ov;
        int          cyc;
        int          stl;
    } exp_t;
    exp_t q[$];

    logic [63:0] last_res = '0;
    logic        last_bo = 1'b0;
    logic        last_ov = 1'b0;
    logic        hold_v = 1'b0;
    logic [63:0] hold_r = '0;
    logic        hold_b = 1'b0;

    ks_subtractor_pipe #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .b_out     (b_out)
`ifdef KS_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    function automatic exp_t model(logic [63:0] ma, logic [63:0] mb, logic mbin);
        logic [64:0] d;
        exp_t        e;
        d     = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
        e.res = d[63:0];
        e.bo  = d[64];
        e.ov  = (ma[63] != mb[63]) && (d[63] != ma[63]);
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on every output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (hold_v) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_result", result, hold_r);
                chk("hold_bout", {63'd0, b_out}, {63'd0, hold_b});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("b_out", {63'd0, b_out}, {63'd0, e.bo});
                    chk("latency", 64'(cycle - e.cyc), 64'(LAT + stall_cnt - e.stl));
`ifdef KS_SUB_OVF_EN
                    chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
                    last_ov = ovf;
`endif
                    last_res = result;
                    last_bo  = b_out;
                    n_out++;
                end
            end
            hold_v = out_valid && !out_ready;
            hold_r = result;
            hold_b = b_out;
            if (out_valid && !out_ready) stall_cnt++;
            if (in_valid && in_ready) begin
                e     = model(a, b, b_in);
                e.cyc = cycle;
                e.stl = stall_cnt;
                q.push_back(e);
            end
        end
    end

    task automatic push(logic [63:0] pa, logic [63:0] pb, logic pbin);
        int   guard = 0;
        logic acc;
        a        = pa;
        b        = pb;
        b_in     = pbin;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(int prev);
        int g = 0;
        while (n_out == prev && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("out_timeout", {63'd0, n_out == prev}, 64'd0);
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic one(logic [63:0] pa, logic [63:0] pb, logic pbin,
                       logic [63:0] er, logic eb, string nm);
        int p = n_out;
        push(pa, pb, pbin);
        wait_out(p);
        chk({nm, "_res"}, last_res, er);
        chk({nm, "_bout"}, {63'd0, last_bo}, {63'd0, eb});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        #1;
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_bout", {63'd0, b_out}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        one(64'd10, 64'd3, 1'b0, 64'd7, 1'b0, "t1");
        one(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "t2a");
        one(64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "t2b");
        one(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, "eq");
        one(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, "wrap");
`ifdef KS_SUB_OVF_EN
        one(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, "ovf1");
        chk("ovf1_flag", {63'd0, last_ov}, 64'd1);
        one(64'd1, 64'd1, 1'b0, 64'd0, 1'b0, "ovf0");
        chk("ovf0_flag", {63'd0, last_ov}, 64'd0);
`endif

        // Back-to-back random stream.
        for (int i = 0; i < 100; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
            push(ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();
        chk("stream_count", 64'(n_out), 64'(105 + 0));

        // Stream with a 5-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 20; i++)
                    push({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_stream_count", 64'(n_out), 64'(125));

        // Reset with operations in flight.
        for (int i = 0; i < 4; i++) push(64'd100 + 64'(i), 64'd1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_stale_output", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        one(64'd9, 64'd4, 1'b0, 64'd5, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
